t05_cb_walker: RTL
==================

// Module: t05_cb_walker
// PURPOSE
//  Parametrised codebook generator: depth-first walk of the Huffman tree in SRAM,
//  one codeword (char, path, length) per leaf over a valid/ready stream. Sits
//  between the htree builder and header/SPI writer. Unlike the first-generation
//  codebook block, it keeps an ancestor stack so backtracking never re-walks
//  from the root, and it flags depth overflow.
// PARAMETERS
//  CHAR_W     8    char index width; element width ELEM_W = CHAR_W+1
//  IDX_W      7    tree node index width (IDX_W <= CHAR_W-1)
//  MAX_DEPTH  128  max codeword length; stack depth and cw_path width
//  LEN_W      $clog2(MAX_DEPTH+1)  width of cw_len
// PORTS
//  clk        in   1            clock
//  rst        in   1            async active-high reset
//  start      in   1            1-cycle pulse: begin walk (ignored unless IDLE)
//  max_index  in   IDX_W        root node index, sampled on start
//  node_req   out  1            node read request; held until node_valid
//  node_addr  out  IDX_W        node index to read; stable while node_req
//  node_valid in   1            node_data valid (same cycle or later than req)
//  node_data  in   2*ELEM_W     {left, right} child elements
//  cw_valid   out  1            codeword available
//  cw_ready   in   1            consumer accepts codeword
//  cw_char    out  CHAR_W       leaf char index
//  cw_path    out  MAX_DEPTH    path bits, LSB-aligned; bit len-1 = root move, bit 0 = last; 0=left,1=right; unused bits 0
//  cw_len     out  LEN_W        codeword length, 1..MAX_DEPTH
//  cw_count   out  CHAR_W+1     codewords accepted since start
//  busy       out  1            high in every state except IDLE/DONE/ERROR
//  done       out  1            walk complete; held until next start
//  error      out  1            depth overflow; held until next start
// BEHAVIOUR
//  Element decode (ELEM_W bits): MSB=0 -> char, char=e[CHAR_W-1:0]; MSB=1 and
//   e[CHAR_W-1]=1, rest 0 -> null (no child); other MSB=1 -> sum, child=e[IDX_W-1:0].
//  Reset: state IDLE; node_req, cw_valid, done, error, busy=0; cw_char, cw_path,
//   cw_len, cw_count=0; depth=0; stack cleared. Reset mid-walk aborts immediately.
//  Stack: entries {node_idx, side}; depth = entries-1; path bit k = side of entry k.
//  States:
//   IDLE  : start -> push {max_index,0}, depth=0, cw_count=0, done/error=0 -> FETCH.
//   FETCH : node_req=1, node_addr=top.node_idx; on node_valid latch {L,R} -> VISIT.
//   VISIT : e = top.side ? R : L.
//           char -> load cw_* (path={path,side}, len=depth+1) -> EMIT.
//           null -> ADVANCE.  sum -> if depth+1==MAX_DEPTH -> ERROR,
//           else push {child,0}, depth++ -> FETCH.
//   EMIT  : cw_valid=1, cw_* stable; on cw_valid&&cw_ready cw_count++ -> ADVANCE.
//   ADVANCE: top.side==0 -> side=1 -> VISIT (latched {L,R} reused, no refetch).
//           top.side==1 -> POP.
//   POP   : depth==0 -> DONE; else pop, depth--; new top.side==0 -> side=1 -> FETCH
//           (parent refetched); new top.side==1 -> POP (one level per cycle).
//   DONE/ERROR: done/error held 1, busy=0; start restarts from IDLE behaviour.
//  Latency: FETCH->VISIT 1 cycle after node_valid; char -> cw_valid next cycle.
//  cw_valid never drops without handshake; cw_* must not change while cw_valid=1.
//  Simultaneous start during busy: ignored. cw_count saturates at 2^(CHAR_W+1)-1.
//  Path arithmetic: shift-left-insert on push, shift-right on pop; bits above
//   depth forced 0. Root null-left with null-right -> DONE, cw_count=0.
// TESTING
//  T1 3-leaf tree: root 2={sum1,'C'0x43}, 1={'A'0x41,'B'0x42}, start -> codewords
//   (0x41,path 00,len2),(0x42,01,2),(0x43,1,1) in order; done, cw_count=3.
//  T2 T1 with cw_ready low 5 cycles on each codeword -> cw_valid held, cw_* stable,
//   same 3 codewords, no duplicates.
//  T3 single char: root 0={'A',null} -> one codeword (0x41,0,1), then done.
//  T4 MAX_DEPTH=2, left-chain tree depth 3 -> error=1, done=0, busy=0, no 3rd-level fetch.
//  T5 node_valid delayed 0 and 3 cycles -> node_addr stable while node_req, same output as T1.
//  T6 rst mid-EMIT -> all outputs 0 next edge; new start reruns T1 cleanly.

Source files
------------

// File: rtl/t05_cb_walker_if.sv
// Node-read and codeword-stream bundle for the codebook walker.
// master = walker side, slave = tree SRAM / codeword consumer side.
interface t05_cb_walker_if #(
   parameter int CHAR_W    = 8,
   parameter int IDX_W     = 7,
   parameter int MAX_DEPTH = 128,
   parameter int LEN_W     = $clog2(MAX_DEPTH + 1)
);
   localparam int ELEM_W = CHAR_W + 1;

   logic                  node_req;
   logic [IDX_W-1:0]      node_addr;
   logic                  node_valid;
   logic [2*ELEM_W-1:0]   node_data;
   logic                  cw_valid;
   logic                  cw_ready;
   logic [CHAR_W-1:0]     cw_char;
   logic [MAX_DEPTH-1:0]  cw_path;
   logic [LEN_W-1:0]      cw_len;

   modport master (
      output node_req, node_addr,
      input  node_valid, node_data,
      output cw_valid, cw_char, cw_path, cw_len,
      input  cw_ready
   );

   modport slave (
      input  node_req, node_addr,
      output node_valid, node_data,
      input  cw_valid, cw_char, cw_path, cw_len,
      output cw_ready
   );
endinterface

// File: rtl/t05_cb_walker.sv
// Depth-first Huffman tree walker: emits one {char, path, len} codeword per leaf,
// keeping an ancestor stack so backtracking never restarts from the root.
//
// state   | meaning
// IDLE    | waiting for start after reset
// FETCH   | reading the node on top of the stack
// VISIT   | decoding the child selected by the top side bit
// EMIT    | codeword presented, waiting for cw_ready
// ADVANCE | left child finished: switch to right, else backtrack
// POP     | unwinding one stack level per cycle
// DONE    | walk complete
// ERROR   | tree deeper than MAX_DEPTH
module t05_cb_walker #(
   parameter int CHAR_W    = 8,
   parameter int IDX_W     = 7,
   parameter int MAX_DEPTH = 128,
   parameter int LEN_W     = $clog2(MAX_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IDX_W-1:0]  max_index,
   t05_cb_walker_if.master   bus,
   output logic [CHAR_W:0]   cw_count,
   output logic              busy,
   output logic              done,
   output logic              error
);
   localparam int ELEM_W = CHAR_W + 1;
   localparam int SP_W   = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
   localparam logic [CHAR_W:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_VISIT, S_EMIT, S_ADVANCE, S_POP, S_DONE, S_ERROR
   } state_t;

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     stk_idx [MAX_DEPTH];
   logic [SP_W-1:0]      depth, depth_inc;
   // Side bits of every stack entry, top of stack at bit 0, root at bit depth.
   logic [MAX_DEPTH-1:0] path_q;
   logic [ELEM_W-1:0]    node_l, node_r, elem;
   logic                 is_char, is_null, at_max;
   logic [CHAR_W-1:0]    cw_char_q;
   logic [MAX_DEPTH-1:0] cw_path_q;
   logic [LEN_W-1:0]     cw_len_q;
   logic [CHAR_W:0]      cnt_q;
   logic                 do_start, do_latch, do_load, do_push, do_side, do_pop, do_count;

   assign elem      = path_q[0] ? node_r : node_l;
   assign is_char   = ~elem[ELEM_W-1];
   assign is_null   = elem[ELEM_W-1] & elem[CHAR_W-1] & (elem[CHAR_W-2:0] == '0);
   assign at_max    = (depth == SP_W'(MAX_DEPTH - 1));
   assign depth_inc = depth + SP_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      do_start  = 1'b0;
      do_latch  = 1'b0;
      do_load   = 1'b0;
      do_push   = 1'b0;
      do_side   = 1'b0;
      do_pop    = 1'b0;
      do_count  = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               do_start  = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            if (bus.node_valid) begin
               do_latch  = 1'b1;
               state_nxt = S_VISIT;
            end
         end
         S_VISIT: begin
            if (is_char) begin
               do_load   = 1'b1;
               state_nxt = S_EMIT;
            end else if (is_null) begin
               state_nxt = S_ADVANCE;
            end else if (at_max) begin
               state_nxt = S_ERROR;
            end else begin
               do_push   = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_EMIT: begin
            if (bus.cw_ready) begin
               do_count  = 1'b1;
               state_nxt = S_ADVANCE;
            end
         end
         S_ADVANCE: begin
            if (!path_q[0]) begin
               do_side   = 1'b1;
               state_nxt = S_VISIT;
            end else begin
               state_nxt = S_POP;
            end
         end
         S_POP: begin
            if (depth == '0) begin
               state_nxt = S_DONE;
            end else begin
               do_pop    = 1'b1;
               // Parent already on its right side means its subtree is finished too.
               state_nxt = path_q[1] ? S_POP : S_FETCH;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_DEPTH; i++) stk_idx[i] <= '0;
         depth     <= '0;
         path_q    <= '0;
         node_l    <= '0;
         node_r    <= '0;
         cw_char_q <= '0;
         cw_path_q <= '0;
         cw_len_q  <= '0;
         cnt_q     <= '0;
      end else begin
         if (do_start) begin
            stk_idx[0] <= max_index;
            depth      <= '0;
            path_q     <= '0;
            cnt_q      <= '0;
         end
         if (do_latch) {node_l, node_r} <= bus.node_data;
         if (do_load) begin
            cw_char_q <= elem[CHAR_W-1:0];
            cw_path_q <= path_q;
            cw_len_q  <= LEN_W'(depth) + LEN_W'(1);
         end
         if (do_push) begin
            stk_idx[depth_inc] <= elem[IDX_W-1:0];
            depth              <= depth_inc;
            path_q             <= {path_q[MAX_DEPTH-2:0], 1'b0};
         end
         if (do_side) path_q[0] <= 1'b1;
         // New top becomes (or already is) its right side; bits above depth shift in as 0.
         if (do_pop) begin
            depth  <= depth - SP_W'(1);
            path_q <= (path_q >> 1) | MAX_DEPTH'(1);
         end
         if (do_count && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      end
   end

   always_comb begin
      bus.node_req  = (state == S_FETCH);
      bus.node_addr = stk_idx[depth];
      bus.cw_valid  = (state == S_EMIT);
      bus.cw_char   = cw_char_q;
      bus.cw_path   = cw_path_q;
      bus.cw_len    = cw_len_q;
      cw_count      = cnt_q;
      busy          = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
      done          = (state == S_DONE);
      error         = (state == S_ERROR);
   end
endmodule
